// File: rtl/ingress_class_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ingress_class_router_pkg
// Description : Shared definitions for the ingress class router: default
//               word and counter widths, class field position and the class
//               index constants naming the four input FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package ingress_class_router_pkg;

  // Default widths
  localparam int DATA_W_DEFAULT = 10;
  localparam int CNT_W_DEFAULT  = 5;

  // Class field sits in the top two bits of a default-width word
  localparam int CLS_W   = 2;
  localparam int CLS_MSB = DATA_W_DEFAULT - 1;
  localparam int CLS_LSB = DATA_W_DEFAULT - CLS_W;
  localparam int NUM_CLS = 4;

  typedef logic [CLS_W-1:0] cls_t;

  // Class index of each destination FIFO
  localparam cls_t CLS_F0 = 2'd0;
  localparam cls_t CLS_F1 = 2'd1;
  localparam cls_t CLS_F2 = 2'd2;
  localparam cls_t CLS_F3 = 2'd3;

endpackage : ingress_class_router_pkg
`default_nettype wire

// File: rtl/ingress_class_router_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Enable-driven up counter that sticks at its maximum value.
//               Asynchronous active-low clear.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous clear, active low
//               en     - count one step when high
//               count  - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/ingress_class_router.sv
`default_nettype none
// ============================================================================
// Module      : ingress_class_router
// Description : Steers a valid/ready word stream into four input FIFOs by the
//               class field in the top two bits of each word. A one-entry
//               holding register absorbs almost-full backpressure; per-class
//               saturating push counters can be read back on request.
// Ports       : clk, reset (async active low)
//               in_valid / in_data / in_ready   - upstream handshake
//               almost_full_F0..F3              - FIFO backpressure flags
//               push_F0..F3 / push_data         - FIFO push strobes and word
//               req_count / req_idx             - counter read request
//               count_out / count_valid         - counter read response
//               idle                            - nothing held, nothing offered
// Revision    : 1.0 - initial release
// ============================================================================
module ingress_class_router
  import ingress_class_router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              almost_full_F0,
  input  logic              almost_full_F1,
  input  logic              almost_full_F2,
  input  logic              almost_full_F3,
  output logic              push_F0,
  output logic              push_F1,
  output logic              push_F2,
  output logic              push_F3,
  output logic [DATA_W-1:0] push_data,
  input  logic              req_count,
  input  logic [1:0]        req_idx,
  output logic [CNT_W-1:0]  count_out,
  output logic              count_valid,
  output logic              idle
);

  // Class field tracks the top of the word when DATA_W is overridden
  localparam int c_CLS_MSB = DATA_W - DATA_W_DEFAULT + CLS_MSB;
  localparam int c_CLS_LSB = DATA_W - DATA_W_DEFAULT + CLS_LSB;

  logic              r_active;
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_hold_word;
  logic [CNT_W-1:0]  r_count_out;
  logic              r_count_valid;

  logic [NUM_CLS-1:0] w_af;
  logic [NUM_CLS-1:0] w_push;
  logic [CNT_W-1:0]   w_cnt [NUM_CLS];
  cls_t               w_dest;
  logic               w_fire;
  logic               w_ready;
  logic               w_accept;

  // Active is low in reset and rises on the first edge after release, which
  // keeps in_ready low until the block has seen a clean clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  assign w_af     = {almost_full_F3, almost_full_F2, almost_full_F1, almost_full_F0};
  assign w_dest   = r_hold_word[c_CLS_MSB:c_CLS_LSB];
  assign w_fire   = r_hold_valid & ~w_af[w_dest];
  // Pass-through ready: a draining holding register can be refilled on the
  // same edge, giving one word per cycle.
  assign w_ready  = r_active & (~r_hold_valid | w_fire);
  assign w_accept = in_valid & w_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_valid <= 1'b0;
      r_hold_word  <= '0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_word  <= in_data;
    end else if (w_fire) begin
      r_hold_valid <= 1'b0;
    end
  end

  generate
    for (genvar k = 0; k < NUM_CLS; k++) begin : g_cls
      assign w_push[k] = w_fire & (w_dest == cls_t'(k));

      sat_counter #(
        .WIDTH (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_push[k]),
        .count (w_cnt[k])
      );
    end
  endgenerate

  // Read samples the counters before this edge's increment lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count_out   <= '0;
      r_count_valid <= 1'b0;
    end else begin
      r_count_valid <= req_count;
      if (req_count) begin
        r_count_out <= w_cnt[req_idx];
      end
    end
  end

  assign push_F0     = w_push[CLS_F0];
  assign push_F1     = w_push[CLS_F1];
  assign push_F2     = w_push[CLS_F2];
  assign push_F3     = w_push[CLS_F3];
  assign push_data   = r_hold_valid ? r_hold_word : '0;
  assign in_ready    = w_ready;
  assign count_out   = r_count_out;
  assign count_valid = r_count_valid;
  assign idle        = r_active & ~r_hold_valid & ~in_valid;

endmodule : ingress_class_router
`default_nettype wire

// File: tb/tb_ingress_class_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_ingress_class_router
// Description : Self-checking bench for ingress_class_router. A reference
//               model built from a one-slot queue and plain integer counters
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ingress_class_router;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic       in_ready;
  logic [3:0] af = '0;
  logic       push_F0, push_F1, push_F2, push_F3;
  logic [9:0] push_data;
  logic       req_count = 1'b0;
  logic [1:0] req_idx = '0;
  logic [4:0] count_out;
  logic       count_valid;
  logic       idle;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [9:0] m_q[$];
  int         m_cnt[4];
  bit         m_active = 0;
  bit         m_cv = 0;
  int         m_co = 0;
  bit         m_fire = 0;
  bit         m_acc = 0;
  int         m_dest = 0;
  bit         last_ready = 0;

  always #5 clk = ~clk;

  ingress_class_router dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .almost_full_F0 (af[0]),
    .almost_full_F1 (af[1]),
    .almost_full_F2 (af[2]),
    .almost_full_F3 (af[3]),
    .push_F0        (push_F0),
    .push_F1        (push_F1),
    .push_F2        (push_F2),
    .push_F3        (push_F3),
    .push_data      (push_data),
    .req_count      (req_count),
    .req_idx        (req_idx),
    .count_out      (count_out),
    .count_valid    (count_valid),
    .idle           (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compare all outputs against the model at the current time.
  task automatic chk_now();
    logic [3:0] e_push;
    logic [9:0] e_pd;
    bit         e_rdy;
    bit         e_idle;
    e_push = '0;
    e_pd   = '0;
    m_fire = 0;
    m_dest = 0;
    if (m_q.size() > 0) begin
      m_dest = int'(m_q[0][9:8]);
      e_pd   = m_q[0];
      m_fire = !af[m_dest];
      if (m_fire) e_push[m_dest] = 1'b1;
    end
    e_rdy      = m_active && (m_q.size() == 0 || m_fire);
    e_idle     = m_active && m_q.size() == 0 && !in_valid;
    m_acc      = in_valid && e_rdy;
    last_ready = e_rdy;
    chk("push_vec", {28'd0, push_F3, push_F2, push_F1, push_F0}, {28'd0, e_push});
    chk("push_data", {22'd0, push_data}, {22'd0, e_pd});
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
    chk("idle", {31'd0, idle}, {31'd0, e_idle});
    chk("count_valid", {31'd0, count_valid}, {31'd0, m_cv});
    chk("count_out", {27'd0, count_out}, m_co);
  endtask

  // Advance one rising edge and apply the same edge to the model.
  task automatic edge_step();
    @(posedge clk);
    if (req_count) begin
      m_co = m_cnt[req_idx];
      m_cv = 1;
    end else begin
      m_cv = 0;
    end
    if (m_fire) begin
      void'(m_q.pop_front());
      if (m_cnt[m_dest] < 31) m_cnt[m_dest]++;
    end
    if (m_acc) m_q.push_back(in_data);
    m_active = 1;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    chk_now();
    edge_step();
  endtask

  task automatic drive(input bit v, input logic [9:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge arrives.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_push", {28'd0, push_F3, push_F2, push_F1, push_F0}, 32'd0);
    chk("rst_data", {22'd0, push_data}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd0);
    chk("rst_cv", {31'd0, count_valid}, 32'd0);
    chk("rst_co", {27'd0, count_out}, 32'd0);
    m_q.delete();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_active = 0;
    m_cv = 0;
    m_co = 0;
    in_valid  = 1'b0;
    req_count = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    #1;
    do_reset();

    // First edge after release only raises active; accept on the second.
    drive(1, 10'h105);
    @(negedge clk);
    chk("ready_before_active", {31'd0, in_ready}, 32'd0);
    chk_now();
    edge_step();
    @(negedge clk);
    chk("ready_accept_0x105", {31'd0, in_ready}, 32'd1);
    chk_now();
    edge_step();
    drive(0, '0);
    @(negedge clk);
    chk("push_f1_0x105", {31'd0, push_F1}, 32'd1);
    chk("push_data_0x105", {22'd0, push_data}, 32'h105);
    chk("ready_during_push", {31'd0, in_ready}, 32'd1);
    chk_now();
    edge_step();

    // Back-to-back stream across all classes.
    for (int i = 0; i < 4; i++) begin
      drive(1, 10'(i * 256));
      tick();
    end
    drive(0, '0);
    repeat (2) tick();

    // Blocked destination holds the word.
    af = 4'b0100;
    drive(1, 10'h2AA);
    tick();
    drive(0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("blocked_ready", {31'd0, in_ready}, 32'd0);
      chk("blocked_push_f2", {31'd0, push_F2}, 32'd0);
      chk_now();
      edge_step();
    end
    af = 4'b0000;
    @(negedge clk);
    chk("unblock_push_f2", {31'd0, push_F2}, 32'd1);
    chk("unblock_data", {22'd0, push_data}, 32'h2AA);
    chk("unblock_ready", {31'd0, in_ready}, 32'd1);
    chk_now();
    edge_step();
    tick();

    // Saturation of class 3 counter after a clean reset.
    do_reset();
    tick();
    for (int i = 0; i < 40; i++) begin
      drive(1, {2'b11, 8'($urandom)});
      tick();
    end
    drive(0, '0);
    repeat (2) tick();
    req_count = 1'b1;
    req_idx   = 2'd3;
    tick();
    req_idx   = 2'd0;
    @(negedge clk);
    chk("sat_cnt3", {27'd0, count_out}, 32'd31);
    chk("sat_cv", {31'd0, count_valid}, 32'd1);
    chk_now();
    edge_step();
    req_count = 1'b0;
    @(negedge clk);
    chk("cnt0_zero", {27'd0, count_out}, 32'd0);
    chk_now();
    edge_step();

    // Reset while a word is held behind an almost-full FIFO.
    af = 4'b0010;
    drive(1, 10'h1C3);
    tick();
    drive(0, '0);
    repeat (2) tick();
    do_reset();
    af = 4'b0000;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      req_count = 1'b1;
      req_idx   = 2'(i);
      tick();
    end
    req_count = 1'b0;
    tick();

    // Read on the same edge as the fifth class-1 fire.
    for (int i = 0; i < 5; i++) begin
      drive(1, 10'h140 + 10'(i));
      tick();
    end
    drive(0, '0);
    req_count = 1'b1;
    req_idx   = 2'd1;
    @(negedge clk);
    chk("fifth_fire", {31'd0, push_F1}, 32'd1);
    chk_now();
    edge_step();
    @(negedge clk);
    chk("read_pre_inc", {27'd0, count_out}, 32'd4);
    chk_now();
    edge_step();
    req_count = 1'b0;
    @(negedge clk);
    chk("read_post_inc", {27'd0, count_out}, 32'd5);
    chk_now();
    edge_step();

    // Randomized traffic with backpressure and reads.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      if (!(in_valid && !last_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 10'($urandom);
      end
      for (int k = 0; k < 4; k++) af[k] = ($urandom_range(0, 3) == 0);
      req_count = ($urandom_range(0, 2) == 0);
      req_idx   = 2'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ingress_class_router
`default_nettype wire

// File: doc/ingress_class_router.md
# ingress_class_router

Upstream feeder for the four input FIFOs (F0–F3) that the round-robin arbiter drains. It accepts a single 10-bit word stream over a valid/ready handshake and steers each word into one of the four FIFOs using its class field, bits [9:8]. A one-entry holding register absorbs backpressure from each FIFO's almost-full flag. Per-class saturating push counters can be read on request.

## Interface
- DATA_W, 10, word width; class field is bits [DATA_W-1:DATA_W-2]
- CNT_W, 5, per-class push counter width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- in_valid  in  1  upstream word valid
- in_data  in  DATA_W  upstream word
- in_ready  out  1  block can accept a word this cycle
- almost_full_F0..almost_full_F3  in  1 each  almost-full flag of input FIFO 0..3
- push_F0..push_F3  out  1 each  push strobe to FIFO 0..3, at most one high per cycle
- push_data  out  DATA_W  word shared by all four FIFOs, valid while any push_Fx is high
- req_count  in  1  counter read request
- req_idx  in  2  class index to read
- count_out  out  CNT_W  counter value returned
- count_valid  out  1  one-cycle strobe qualifying count_out
- idle  out  1  holding register empty and in_valid low

## Operation
- Registers:
  - active flag: 0 in reset, 1 from the first edge after release.
  - hold_valid and hold_word.
  - four CNT_W counters.
  - count_out and count_valid.
- dest = hold_word[9:8].
- fire = hold_valid & ~almost_full_F[dest].
- push_F[dest] = fire, all other push_Fx = 0.
- push_data = hold_word when hold_valid, else 0.
- in_ready = active & (~hold_valid | fire). This is pass-through, so the holding register can be refilled in the same cycle it drains.
- accept = in_valid & in_ready. On accept, hold_word <= in_data and hold_valid <= 1.
- On fire without accept, hold_valid <= 0.
- Blocked word: if almost_full of the destination is high, the word stays held, in_ready stays 0, and no push is issued. The word is never dropped or reordered.
- Counters: counter[dest] increments on fire and saturates at 2^CNT_W-1 (31); no wrap-around.
- Counter read: req_count at edge N gives count_valid=1 during cycle N+1, with count_out = counter[req_idx] as sampled before any same-edge increment. count_out holds its value when count_valid is 0.
- Reset (any time, including mid-operation):
  - Held word is discarded and all counters clear.
  - All outputs read 0, including in_ready and idle.
  - Reset takes effect immediately (asynchronous); release is sampled on clk.
- idle = active & ~hold_valid & ~in_valid.

## Timing
- Latency 1 cycle: a word accepted at edge N drives push_Fx and push_data during cycle N+1, and the FIFO captures it at edge N+1 if its almost_full is low.
- Throughput 1 word per cycle while the destination FIFOs are not almost full.
- almost_full is sampled combinationally in the cycle it is seen. Asserting it in cycle N+1 suppresses that push and deasserts in_ready in the same cycle.
- Upstream must hold in_data stable while in_valid=1 and in_ready=0.
- Counter read latency is 1 cycle. Back-to-back requests are allowed and return one result per cycle.
- First accept is possible at the second edge after reset release.

## Structure
- Shared package holds:
  - DATA_W and CNT_W defaults
  - class field bit positions
  - class index constants CLS_F0..CLS_F3 = 0..3
- The push/ready logic stays in the main module.
- One sub-module, sat_counter: an enable-driven saturating counter with asynchronous active-low clear, instantiated four times.

## Test plan
- Reset release, word 10'b01_0000_0101 with in_valid → push_F1=1 with push_data=0x105 one cycle later, and in_ready high through the cycle.
- Stream 0x000, 0x100, 0x200, 0x300 on consecutive cycles, all almost_full low → push_F0..push_F3 on consecutive cycles, no bubbles.
- almost_full_F2=1, send 0x2AA → in_ready=0 and no push for 5 cycles; drop almost_full_F2 → push_F2 with 0x2AA the same cycle, and in_ready returns to 1.
- Send 40 words of class 3, then req_count with req_idx=3 → count_valid=1 and count_out=31 (saturated). req_idx=0 → count_out=0.
- Assert reset while a word is held with its destination almost full → after release no push ever appears for that word and all counters read 0.
- req_count on the same edge as the 5th class-1 fire → count_out=4; the next read returns 5.
